// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
//
// MEM stage of a five-stage pipeline with an EX/MEM -> MEM/WB register and a
// handshaked data-memory port. Non-memory instructions pass straight through
// in one cycle. An aligned load or store spends one IDLE cycle raising stall,
// then sits in REQ driving the memory request until mem_ack_i arrives or the
// wait counter reaches TIMEOUT. A misaligned access is never issued: it
// becomes a bubble and sets a sticky flag. While the stage is stalled, the
// MEM/WB register receives bubbles, so writeback never sees a half-finished
// access.
//
// Parameters
//   TIMEOUT      max REQ cycles without mem_ack_i before abort (1..255)
//
// Ports
//   clk_i        clock, all state on rising edge
//   rst_i        asynchronous, active-high reset
//   RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i   EX/MEM control fields
//   ALUResult_i  ALU result / memory address
//   RS2data_i    store data
//   RDaddr_i     destination register
//   mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o    data-memory request
//   mem_ack_i, mem_rdata_i                          data-memory response
//   stall_o      freeze upstream stages and the EX/MEM register
//   RegWrite_o, MemtoReg_o, ReadData_o, ALUResult_o, RDaddr_o   MEM/WB
//   err_o        sticky: a request timed out
//   misalign_o   sticky: a misaligned access was dropped
// -----------------------------------------------------------------------------
module mem_access_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        RegWrite_i,
  input  logic        MemtoReg_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] ALUResult_i,
  input  logic [31:0] RS2data_i,
  input  logic [4:0]  RDaddr_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic        RegWrite_o,
  output logic        MemtoReg_o,
  output logic [31:0] ReadData_o,
  output logic [31:0] ALUResult_o,
  output logic [4:0]  RDaddr_o,
  output logic        err_o,
  output logic        misalign_o
);

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t     state_q;
  state_t     state_d;
  logic [7:0] wait_cnt_q;

  logic mem_op;
  logic aligned;
  logic timed_out;

  // Per-cycle decisions made by the output process.
  logic wb_pass;       // MEM/WB takes the current instruction (else a bubble)
  logic wb_use_rdata;  // ReadData_o takes mem_rdata_i (else 0)
  logic cnt_inc;
  logic cnt_clr;
  logic set_err;
  logic set_misalign;
  logic stall_raw;

  assign mem_op    = MemRead_i | MemWrite_i;
  assign aligned   = (ALUResult_i[1:0] == 2'b00);
  assign timed_out = (wait_cnt_q == TIMEOUT_CNT);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking (=) here would create order-dependent races.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven from always_comb gets a default on the first
  // line, so no path through the branches can leave it unassigned and infer
  // a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (mem_op && aligned) state_d = REQ;
      end
      REQ: begin
        // Either completion or abort returns to IDLE.
        if (mem_ack_i || timed_out) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    wb_pass      = 1'b0;
    wb_use_rdata = 1'b0;
    cnt_inc      = 1'b0;
    cnt_clr      = 1'b0;
    set_err      = 1'b0;
    set_misalign = 1'b0;
    stall_raw    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // mem_ack_i is deliberately not looked at here: a stray ack outside
        // REQ has no meaning.
        if (!mem_op) begin
          wb_pass = 1'b1;
        end else if (aligned) begin
          // Hold the instruction in EX/MEM for the REQ phase.
          stall_raw = 1'b1;
        end else begin
          // Dropped access: let the pipeline move on, leave a bubble.
          set_misalign = 1'b1;
        end
      end

      REQ: begin
        mem_req_o   = 1'b1;
        mem_we_o    = MemWrite_i;
        mem_addr_o  = ALUResult_i;
        mem_wdata_o = RS2data_i;
        if (mem_ack_i) begin
          // Ack has priority over a coincident timeout.
          wb_pass      = 1'b1;
          wb_use_rdata = !MemWrite_i;
          cnt_clr      = 1'b1;
        end else if (timed_out) begin
          // Abort: release the pipeline, the instruction retires as a bubble.
          set_err = 1'b1;
          cnt_clr = 1'b1;
        end else begin
          stall_raw = 1'b1;
          cnt_inc   = 1'b1;
        end
      end

      default: ;
    endcase

    // The stall path is combinational from EX/MEM inputs, so it must be
    // masked explicitly while reset is held.
    stall_o = stall_raw & ~rst_i;
  end

  // ---------------------------------------------------------------------------
  // Wait counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_cnt_q <= '0;
    end else if (cnt_clr) begin
      wait_cnt_q <= '0;
    end else if (cnt_inc) begin
      wait_cnt_q <= wait_cnt_q + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // MEM/WB pipeline register
  // ---------------------------------------------------------------------------
  // NOTE: these are individual pipeline flops, not a memory array, so they
  // all take the reset; downstream logic relies on them reading as a bubble
  // during and right after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      RegWrite_o  <= 1'b0;
      MemtoReg_o  <= 1'b0;
      ReadData_o  <= '0;
      ALUResult_o <= '0;
      RDaddr_o    <= '0;
    end else if (wb_pass) begin
      RegWrite_o  <= RegWrite_i;
      MemtoReg_o  <= MemtoReg_i;
      ReadData_o  <= wb_use_rdata ? mem_rdata_i : 32'd0;
      ALUResult_o <= ALUResult_i;
      RDaddr_o    <= RDaddr_i;
    end else begin
      // A bubble is all zeros, so it can never write the register file.
      RegWrite_o  <= 1'b0;
      MemtoReg_o  <= 1'b0;
      ReadData_o  <= '0;
      ALUResult_o <= '0;
      RDaddr_o    <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky status flags, cleared only by reset
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_o      <= 1'b0;
      misalign_o <= 1'b0;
    end else begin
      if (set_err)      err_o      <= 1'b1;
      if (set_misalign) misalign_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_access_stage
//
// Self-checking bench for mem_access_stage (TIMEOUT=4). Single-cycle IDLE
// behaviour comes from a vector table; loads, stores, back-to-back accesses,
// timeout, ack-at-timeout and mid-access reset are hand-written sequences.
// Expected MEM/WB contents are queued when a cycle's inputs are driven and
// compared after the clock edge that loads them.
// -----------------------------------------------------------------------------
module tb_mem_access_stage;

  localparam int TO = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i;
  logic [31:0] ALUResult_i, RS2data_i;
  logic [4:0]  RDaddr_i;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        stall_o;
  logic        RegWrite_o, MemtoReg_o;
  logic [31:0] ReadData_o, ALUResult_o;
  logic [4:0]  RDaddr_o;
  logic        err_o, misalign_o;

  mem_access_stage #(.TIMEOUT(TO)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .RegWrite_i  (RegWrite_i),
    .MemtoReg_i  (MemtoReg_i),
    .MemRead_i   (MemRead_i),
    .MemWrite_i  (MemWrite_i),
    .ALUResult_i (ALUResult_i),
    .RS2data_i   (RS2data_i),
    .RDaddr_i    (RDaddr_i),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i),
    .stall_o     (stall_o),
    .RegWrite_o  (RegWrite_o),
    .MemtoReg_o  (MemtoReg_o),
    .ReadData_o  (ReadData_o),
    .ALUResult_o (ALUResult_o),
    .RDaddr_o    (RDaddr_o),
    .err_o       (err_o),
    .misalign_o  (misalign_o)
  );

  always #5 clk_i = ~clk_i;

  // Expected MEM/WB content; when full=0 only the bubble control fields
  // (RegWrite, MemtoReg, RDaddr) are defined.
  typedef struct {
    logic        full;
    logic        rw;
    logic        mtr;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] rdata;
  } wb_t;

  typedef struct {
    string       name;
    logic        rw, mtr, mr, mw;
    logic [31:0] alu, rs2;
    logic [4:0]  rd;
    logic        ack;
    logic [31:0] rdata;
    logic        exp_stall;
    logic        exp_req;
    wb_t         exp_wb;
  } vec_t;

  int  checks   = 0;
  int  failures = 0;
  wb_t sb[$];

  localparam wb_t BUBBLE = '{full: 1'b0, rw: 1'b0, mtr: 1'b0, rd: 5'd0,
                             alu: 32'd0, rdata: 32'd0};

  function automatic wb_t pass_wb(input logic rw, input logic mtr,
                                  input logic [4:0] rd, input logic [31:0] alu,
                                  input logic [31:0] rdata);
    wb_t w;
    w.full = 1'b1; w.rw = rw; w.mtr = mtr; w.rd = rd; w.alu = alu; w.rdata = rdata;
    return w;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic rw, input logic mtr, input logic mr,
                        input logic mw, input logic [31:0] alu,
                        input logic [31:0] rs2, input logic [4:0] rd,
                        input logic ack, input logic [31:0] rdata);
    RegWrite_i = rw; MemtoReg_i = mtr; MemRead_i = mr; MemWrite_i = mw;
    ALUResult_i = alu; RS2data_i = rs2; RDaddr_i = rd;
    mem_ack_i = ack; mem_rdata_i = rdata;
  endtask

  // Called just after a falling edge with inputs already driven. Checks the
  // combinational outputs, queues the expected MEM/WB value, then compares it
  // after the rising edge, returning on the next falling edge.
  task automatic cycle(input string name, input logic exp_stall,
                       input logic exp_req, input wb_t exp_wb);
    wb_t e;
    #1;
    check({name, " stall_o"}, 32'(stall_o), 32'(exp_stall));
    check({name, " mem_req_o"}, 32'(mem_req_o), 32'(exp_req));
    sb.push_back(exp_wb);
    @(posedge clk_i);
    #1;
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      check({name, " RegWrite_o"}, 32'(RegWrite_o), 32'(e.rw));
      check({name, " MemtoReg_o"}, 32'(MemtoReg_o), 32'(e.mtr));
      check({name, " RDaddr_o"}, 32'(RDaddr_o), 32'(e.rd));
      if (e.full) begin
        check({name, " ALUResult_o"}, ALUResult_o, e.alu);
        check({name, " ReadData_o"}, ReadData_o, e.rdata);
      end
    end
    @(negedge clk_i);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " mem_req_o"}, 32'(mem_req_o), 32'd0);
    check({name, " mem_we_o"}, 32'(mem_we_o), 32'd0);
    check({name, " stall_o"}, 32'(stall_o), 32'd0);
    check({name, " RegWrite_o"}, 32'(RegWrite_o), 32'd0);
    check({name, " MemtoReg_o"}, 32'(MemtoReg_o), 32'd0);
    check({name, " ReadData_o"}, ReadData_o, 32'd0);
    check({name, " ALUResult_o"}, ALUResult_o, 32'd0);
    check({name, " RDaddr_o"}, 32'(RDaddr_o), 32'd0);
    check({name, " err_o"}, 32'(err_o), 32'd0);
    check({name, " misalign_o"}, 32'(misalign_o), 32'd0);
  endtask

  // Hard stop if the bench itself ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];

    vecs.push_back('{"alu_basic", 1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 5'd5,
                     1'b0, 32'h0, 1'b0, 1'b0,
                     pass_wb(1'b1, 1'b0, 5'd5, 32'h10, 32'h0)});
    vecs.push_back('{"alu_max", 1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 5'd31,
                     1'b0, 32'h0, 1'b0, 1'b0,
                     pass_wb(1'b1, 1'b1, 5'd31, 32'hFFFF_FFFF, 32'h0)});
    vecs.push_back('{"alu_nowrite", 1'b0, 1'b0, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd7,
                     1'b0, 32'h0, 1'b0, 1'b0,
                     pass_wb(1'b0, 1'b0, 5'd7, 32'h1234, 32'h0)});
    vecs.push_back('{"stray_ack", 1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0, 5'd2,
                     1'b1, 32'hAAAA_5555, 1'b0, 1'b0,
                     pass_wb(1'b1, 1'b0, 5'd2, 32'h20, 32'h0)});
    vecs.push_back('{"misalign_load", 1'b1, 1'b1, 1'b1, 1'b0, 32'h103, 32'h0, 5'd3,
                     1'b0, 32'h0, 1'b0, 1'b0, BUBBLE});
    vecs.push_back('{"misalign_store", 1'b0, 1'b0, 1'b0, 1'b1, 32'h42, 32'h99, 5'd0,
                     1'b0, 32'h0, 1'b0, 1'b0, BUBBLE});
    vecs.push_back('{"alu_after_mis", 1'b1, 1'b0, 1'b0, 1'b0, 32'h44, 32'h0, 5'd9,
                     1'b0, 32'h0, 1'b0, 1'b0,
                     pass_wb(1'b1, 1'b0, 5'd9, 32'h44, 32'h0)});

    // ---- reset with an aligned load presented: stall must stay low ----
    rst_i = 1'b1;
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 5'd1, 1'b0, 32'h0);
    #1;
    check_reset_outputs("reset");
    @(posedge clk_i); #1;
    check_reset_outputs("reset_edge");
    @(negedge clk_i);
    rst_i = 1'b0;

    // ---- table-driven IDLE vectors ----
    for (int i = 0; i < vecs.size(); i++) begin
      set_in(vecs[i].rw, vecs[i].mtr, vecs[i].mr, vecs[i].mw, vecs[i].alu,
             vecs[i].rs2, vecs[i].rd, vecs[i].ack, vecs[i].rdata);
      #1;
      check({vecs[i].name, " mem_we_o"}, 32'(mem_we_o), 32'd0);
      cycle(vecs[i].name, vecs[i].exp_stall, vecs[i].exp_req, vecs[i].exp_wb);
    end
    check("misalign sticky", 32'(misalign_o), 32'd1);
    check("err after table", 32'(err_o), 32'd0);

    // ---- load, ack on third REQ cycle ----
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 5'd9, 1'b0, 32'h0);
    cycle("load idle", 1'b1, 1'b0, BUBBLE);
    #1;
    check("load addr", mem_addr_o, 32'h100);
    check("load we", 32'(mem_we_o), 32'd0);
    cycle("load req1", 1'b1, 1'b1, BUBBLE);
    cycle("load req2", 1'b1, 1'b1, BUBBLE);
    mem_ack_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D;
    cycle("load ack", 1'b0, 1'b1,
          pass_wb(1'b1, 1'b1, 5'd9, 32'h100, 32'hCAFE_F00D));

    // ---- store ----
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 32'h1234, 5'd0, 1'b0, 32'h0);
    cycle("store idle", 1'b1, 1'b0, BUBBLE);
    #1;
    check("store we", 32'(mem_we_o), 32'd1);
    check("store wdata", mem_wdata_o, 32'h1234);
    check("store addr", mem_addr_o, 32'h40);
    cycle("store req1", 1'b1, 1'b1, BUBBLE);
    mem_ack_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    cycle("store ack", 1'b0, 1'b1, pass_wb(1'b0, 1'b0, 5'd0, 32'h40, 32'h0));

    // ---- back-to-back loads, each acked immediately (2-cycle latency) ----
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 32'h80, 32'h0, 5'd10, 1'b0, 32'h0);
    cycle("b2b0 idle", 1'b1, 1'b0, BUBBLE);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h1111_2222;
    cycle("b2b0 ack", 1'b0, 1'b1, pass_wb(1'b1, 1'b1, 5'd10, 32'h80, 32'h1111_2222));
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 32'h84, 32'h0, 5'd11, 1'b1, 32'h3333_4444);
    cycle("b2b1 idle", 1'b1, 1'b0, BUBBLE);
    cycle("b2b1 ack", 1'b0, 1'b1, pass_wb(1'b1, 1'b1, 5'd11, 32'h84, 32'h3333_4444));

    // ---- ack coincident with timeout: ack wins, err stays 0 ----
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 5'd6, 1'b0, 32'h0);
    cycle("ackto idle", 1'b1, 1'b0, BUBBLE);
    for (int i = 0; i < TO; i++) cycle("ackto wait", 1'b1, 1'b1, BUBBLE);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h0BAD_F00D;
    cycle("ackto ack", 1'b0, 1'b1, pass_wb(1'b1, 1'b1, 5'd6, 32'h300, 32'h0BAD_F00D));
    check("ackto err", 32'(err_o), 32'd0);

    // ---- timeout abort ----
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 5'd4, 1'b0, 32'h0);
    cycle("to idle", 1'b1, 1'b0, BUBBLE);
    for (int i = 0; i < TO; i++) cycle("to wait", 1'b1, 1'b1, BUBBLE);
    check("to err before", 32'(err_o), 32'd0);
    cycle("to abort", 1'b0, 1'b1, BUBBLE);
    check("to ReadData_o", ReadData_o, 32'd0);
    check("to err set", 32'(err_o), 32'd1);
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 32'h204, 32'h0, 5'd8, 1'b0, 32'h0);
    cycle("after_to idle", 1'b1, 1'b0, BUBBLE);
    mem_ack_i = 1'b1; mem_rdata_i = 32'h55AA_55AA;
    cycle("after_to ack", 1'b0, 1'b1, pass_wb(1'b1, 1'b1, 5'd8, 32'h204, 32'h55AA_55AA));
    check("err sticky", 32'(err_o), 32'd1);

    // ---- reset pulsed mid-REQ ----
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 32'h400, 32'h0, 5'd12, 1'b0, 32'h0);
    cycle("rst idle", 1'b1, 1'b0, BUBBLE);
    #1;
    check("rst pre req", 32'(mem_req_o), 32'd1);
    rst_i = 1'b1;
    #1;
    check_reset_outputs("rst async");
    @(posedge clk_i); #1;
    check_reset_outputs("rst held");
    @(negedge clk_i);
    rst_i = 1'b0;
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h77, 32'h0, 5'd13, 1'b1, 32'hFFFF_0000);
    cycle("post_rst alu", 1'b0, 1'b0, pass_wb(1'b1, 1'b0, 5'd13, 32'h77, 32'h0));
    check("post_rst err", 32'(err_o), 32'd0);
    check("post_rst misalign", 32'(misalign_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
